// File: rtl/square_loop_acq_ctrl_if.sv
// square_loop_acq_ctrl_if
//   Bundles the control-side signals of the squaring-loop acquisition
//   controller. clk/rst stay plain ports on the controller itself.
//   Signals:
//     en        level, 1 = run acquisition, 0 = return to idle
//     df        signed 28-bit loop-filter output
//     df_valid  df qualifier
//     startf    32-bit NCO phase increment (registered)
//     loop_clr  1-cycle loop-filter integrator clear
//     gain_sel  0 = wide (acquire) gain, 1 = narrow (track) gain
//     locked    lock indicator
//     fail      sticky acquisition failure until en drops
//   master: the environment driving en/df; slave: the controller.
interface square_loop_acq_ctrl_if;
   logic               en;
   logic signed [27:0] df;
   logic               df_valid;
   logic [31:0]        startf;
   logic               loop_clr;
   logic               gain_sel;
   logic               locked;
   logic               fail;

   modport master (
      output en, df, df_valid,
      input  startf, loop_clr, gain_sel, locked, fail
   );

   modport slave (
      input  en, df, df_valid,
      output startf, loop_clr, gain_sel, locked, fail
   );
endinterface

// File: rtl/square_loop_acq_ctrl.sv
// square_loop_acq_ctrl
//   Acquisition/lock controller for the squaring carrier-recovery loop.
//   Sweeps the NCO start increment from F_MIN to F_MAX in F_STEP steps,
//   measuring the df excursion (max-min) per window of WIN_LEN valid
//   samples after SETTLE_LEN settling samples. Declares lock on a quiet
//   window, selects narrow gain, and drops lock after UNLOCK_CNT
//   consecutive noisy windows. Gives up (fail) after MAX_SWEEPS sweeps.
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active high
//     bus  square_loop_acq_ctrl_if.slave (en, df, df_valid in;
//          startf, loop_clr, gain_sel, locked, fail out, all registered)
//   Build option: define SQACQ_TRACK_EN to recentre startf by the
//   locking window's (max+min)/2 on lock, with one loop_clr pulse.
module square_loop_acq_ctrl #(
   parameter logic [31:0] F_MIN      = 32'd805306368,
   parameter logic [31:0] F_MAX      = 32'd939524096,
   parameter logic [31:0] F_STEP     = 32'd8388608,
   parameter int unsigned SETTLE_LEN = 256,
   parameter int unsigned WIN_LEN    = 1024,
   parameter int unsigned LOCK_TH    = 4096,
   parameter int unsigned UNLOCK_TH  = 16384,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter int unsigned MAX_SWEEPS = 3
) (
   input logic                   clk,
   input logic                   rst,
   square_loop_acq_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2((WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN);
   localparam int unsigned SW_W  = $clog2(MAX_SWEEPS + 1);
   localparam int unsigned BAD_W = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_LOCKED, ST_FAIL} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               first_q, win_done_q;
   logic signed [27:0] min_q, max_q;
   logic [SW_W-1:0]    sweep_q, sweep_d;
   logic [BAD_W-1:0]   bad_q, bad_d;
   logic [31:0]        startf_q, startf_d;
   logic               loop_clr_q, loop_clr_d;
   logic               gain_q, gain_d;
   logic               locked_q, locked_d;
   logic               fail_q, fail_d;

   logic [28:0]        exc;
   logic [32:0]        step_sum;
   logic               lock_win, bad_win, wrap, last_sweep, lose_lock;

   always_comb begin
      exc        = {max_q[27], max_q} - {min_q[27], min_q};
      step_sum   = {1'b0, startf_q} + {1'b0, F_STEP};
      lock_win   = exc < 29'(LOCK_TH);
      bad_win    = exc >= 29'(UNLOCK_TH);
      wrap       = step_sum > {1'b0, F_MAX};
      last_sweep = sweep_q == SW_W'(MAX_SWEEPS - 1);
      lose_lock  = win_done_q && bad_win && (bad_q == BAD_W'(UNLOCK_CNT - 1));
   end

`ifdef SQACQ_TRACK_EN
   logic signed [28:0] mid_sum;
   logic signed [31:0] mid_ext;
   always_comb begin
      mid_sum = {max_q[27], max_q} + {min_q[27], min_q};
      mid_ext = 32'(mid_sum) >>> 1;
   end
`endif

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         first_q    <= 1'b1;
         win_done_q <= 1'b0;
         min_q      <= '0;
         max_q      <= '0;
         sweep_q    <= '0;
         bad_q      <= '0;
         startf_q   <= F_MIN;
         loop_clr_q <= 1'b0;
         gain_q     <= 1'b0;
         locked_q   <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         bad_q      <= bad_d;
         startf_q   <= startf_d;
         loop_clr_q <= loop_clr_d;
         gain_q     <= gain_d;
         locked_q   <= locked_d;
         fail_q     <= fail_d;
         win_done_q <= 1'b0;
         // Any state change restarts the sample count; a sample arriving in
         // a LOCKED decision cycle that stays LOCKED opens the next window.
         if (state_d != state_q) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
         end else if (bus.df_valid) begin
            if (state_q == ST_SETTLE) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end else if (state_q == ST_MEASURE || state_q == ST_LOCKED) begin
               if (first_q || bus.df < min_q) min_q <= bus.df;
               if (first_q || bus.df > max_q) max_q <= bus.df;
               first_q <= 1'b0;
               if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
                  cnt_q      <= '0;
                  win_done_q <= 1'b1;
                  first_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (!bus.en) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:    state_d = ST_SETTLE;
            ST_SETTLE:  if (bus.df_valid && cnt_q == CNT_W'(SETTLE_LEN - 1)) state_d = ST_MEASURE;
            ST_MEASURE: if (win_done_q) begin
                           if (lock_win)                state_d = ST_LOCKED;
                           else if (wrap && last_sweep) state_d = ST_FAIL;
                           else                         state_d = ST_SETTLE;
                        end
            ST_LOCKED:  if (lose_lock) state_d = ST_SETTLE;
            ST_FAIL:    state_d = ST_FAIL;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs and sweep/bad counters.
   always_comb begin
      startf_d   = startf_q;
      loop_clr_d = 1'b0;
      gain_d     = gain_q;
      locked_d   = locked_q;
      fail_d     = fail_q;
      sweep_d    = sweep_q;
      bad_d      = bad_q;
      if (!bus.en) begin
         gain_d   = 1'b0;
         locked_d = 1'b0;
         fail_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               startf_d   = F_MIN;
               sweep_d    = '0;
               bad_d      = '0;
               loop_clr_d = 1'b1;
            end
            ST_MEASURE: if (win_done_q) begin
               if (lock_win) begin
                  locked_d = 1'b1;
                  gain_d   = 1'b1;
                  bad_d    = '0;
`ifdef SQACQ_TRACK_EN
                  startf_d   = startf_q + mid_ext;
                  loop_clr_d = 1'b1;
`endif
               end else if (wrap) begin
                  sweep_d = sweep_q + SW_W'(1);
                  if (last_sweep) begin
                     fail_d = 1'b1;
                  end else begin
                     startf_d   = F_MIN;
                     loop_clr_d = 1'b1;
                  end
               end else begin
                  startf_d   = step_sum[31:0];
                  loop_clr_d = 1'b1;
               end
            end
            ST_LOCKED: if (win_done_q) begin
               if (lose_lock) begin
                  locked_d   = 1'b0;
                  gain_d     = 1'b0;
                  loop_clr_d = 1'b1;
                  sweep_d    = '0;
                  bad_d      = '0;
               end else if (bad_win) begin
                  bad_d = bad_q + BAD_W'(1);
               end else begin
                  bad_d = '0;
               end
            end
            ST_FAIL: begin
               fail_d   = 1'b1;
               locked_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.startf   = startf_q;
   assign bus.loop_clr = loop_clr_q;
   assign bus.gain_sel = gain_q;
   assign bus.locked   = locked_q;
   assign bus.fail     = fail_q;
endmodule
